// File: rtl/fe_test_sequencer.sv
// fe_test_sequencer: steps the front-end test generator through its enabled test modes
//
// Optional feature: define FE_SEQ_LOOP_EN to repeat the enabled modes until abort
// instead of finishing with a single pass and a done pulse.
//
// Ports:
//   i_clk, i_reset        mclk and synchronous active-high reset
//   i_start, i_abort      one-clk CPU pulses; abort wins over start
//   i_rate_sel            sample rate select, latched on start
//   i_dwell_samples       sample periods per mode (0 acts as 1), latched on start
//   i_mode_mask           bit i enables mode i+1, latched on start
//   i_tri_inc             triangle slope for mode 3, latched on start
//   o_fe_run              generator run enable
//   o_fe_select           generator data_out_select
//   o_fe_tri_inc          generator triangle_inc_reg
//   o_smp_strobe          one pulse per sample period while running
//   o_busy, o_done        CPU status
//   o_cur_mode            mode being driven, 0 when idle or in a gap
module fe_test_sequencer #(
    parameter int DWELL_W = 16,
    parameter int DIV_W   = 11
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [2:0]         i_rate_sel,
    input  logic [DWELL_W-1:0] i_dwell_samples,
    input  logic [3:0]         i_mode_mask,
    input  logic [7:0]         i_tri_inc,
    output logic               o_fe_run,
    output logic [2:0]         o_fe_select,
    output logic [7:0]         o_fe_tri_inc,
    output logic               o_smp_strobe,
    output logic               o_busy,
    output logic               o_done,
    output logic [2:0]         o_cur_mode
);
`ifdef FE_SEQ_LOOP_EN
    localparam bit LP_LOOP = 1'b1;
`else
    localparam bit LP_LOOP = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div_term;
    logic [DIV_W-1:0]   r_div;
    logic [DWELL_W-1:0] r_dwell_last;
    logic [DWELL_W-1:0] r_dwell;
    logic [3:0]         r_mask;
    logic [7:0]         r_tri;
    logic [2:0]         r_mode;
    logic               r_gap;

    logic [DIV_W-1:0]   w_term;
    logic [2:0]         w_first;
    logic [2:0]         w_next;
    logic [2:0]         w_wrap;
    logic               w_last;

    // lowest enabled mode strictly above 'after', 0 if none
    function automatic logic [2:0] f_next(input logic [3:0] m, input logic [2:0] after);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 0; k < 4; k++)
            if (m[k] && 3'(k + 1) > after && r == 3'd0)
                r = 3'(k + 1);
        return r;
    endfunction

    always_comb begin
        w_term  = (i_rate_sel == 3'd0) ? DIV_W'(255)  :
                  (i_rate_sel == 3'd1) ? DIV_W'(511)  :
                  (i_rate_sel == 3'd3) ? DIV_W'(1114) :
                  (i_rate_sel == 3'd4) ? DIV_W'(556)  : DIV_W'(1023);
        w_first = f_next(i_mode_mask, 3'd0);
        w_next  = f_next(r_mask, r_mode);
        w_wrap  = f_next(r_mask, 3'd0);
        // the strobe is visible for one cycle; the step ends on the one that completes the dwell
        w_last  = o_smp_strobe && (r_dwell == r_dwell_last);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_abort) begin
            r_state      <= S_IDLE;
            r_div_term   <= '0;
            r_div        <= '0;
            r_dwell_last <= '0;
            r_dwell      <= '0;
            r_mask       <= '0;
            r_tri        <= '0;
            r_mode       <= '0;
            r_gap        <= 1'b0;
            o_fe_run     <= 1'b0;
            o_fe_select  <= '0;
            o_fe_tri_inc <= '0;
            o_smp_strobe <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_cur_mode   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_div_term   <= w_term;
                        r_dwell_last <= (i_dwell_samples == '0) ? '0 : i_dwell_samples - 1'b1;
                        r_mask       <= i_mode_mask;
                        r_tri        <= i_tri_inc;
                        r_mode       <= w_first;
                        r_gap        <= 1'b0;
                        r_div        <= '0;
                        r_dwell      <= '0;
                        o_busy       <= 1'b1;
                        r_state      <= (i_mode_mask != 4'd0) ? S_GAP : S_DONE;
                    end
                end
                S_GAP: begin
                    r_gap <= 1'b1;
                    if (r_gap) begin
                        r_state      <= S_RUN;
                        o_fe_run     <= 1'b1;
                        o_fe_select  <= r_mode;
                        o_cur_mode   <= r_mode;
                        o_fe_tri_inc <= (r_mode == 3'd3) ? r_tri : 8'd0;
                    end
                end
                S_RUN: begin
                    r_div        <= (r_div == r_div_term) ? '0 : r_div + 1'b1;
                    o_smp_strobe <= (r_div == r_div_term);
                    if (o_smp_strobe)
                        r_dwell <= r_dwell + 1'b1;
                    if (w_last) begin
                        o_fe_run     <= 1'b0;
                        o_fe_select  <= '0;
                        o_fe_tri_inc <= '0;
                        o_cur_mode   <= '0;
                        o_smp_strobe <= 1'b0;
                        r_div        <= '0;
                        r_dwell      <= '0;
                        r_gap        <= 1'b0;
                        if (w_next != 3'd0 || LP_LOOP) begin
                            r_mode  <= (w_next != 3'd0) ? w_next : w_wrap;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fe_test_sequencer.sv
// tb_fe_test_sequencer: checks fe_test_sequencer against a per-cycle expected output trace
module tb_fe_test_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [2:0]  rate_sel;
    logic [15:0] dwell;
    logic [3:0]  mask;
    logic [7:0]  tinc;
    logic        fe_run, smp_strobe, busy, done;
    logic [2:0]  fe_select, cur_mode;
    logic [7:0]  fe_tri_inc;
    logic [17:0] act;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [17:0] exp_q[$];

`ifdef FE_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [3:0]  mask;
        logic [2:0]  rate;
        logic [15:0] dwell;
        logic [7:0]  tinc;
        bit          tamper;
        int          exp_len;
        int          exp_stb;
        logic [15:0] exp_modes;
    } vec_t;

    always #5 clk = ~clk;

    fe_test_sequencer dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
        .i_rate_sel(rate_sel), .i_dwell_samples(dwell), .i_mode_mask(mask), .i_tri_inc(tinc),
        .o_fe_run(fe_run), .o_fe_select(fe_select), .o_fe_tri_inc(fe_tri_inc),
        .o_smp_strobe(smp_strobe), .o_busy(busy), .o_done(done), .o_cur_mode(cur_mode)
    );

    assign act = {fe_run, fe_select, fe_tri_inc, smp_strobe, busy, done, cur_mode};

    function automatic logic [17:0] pk(input bit run, input logic [2:0] sel, input logic [7:0] t,
                                       input bit stb, input bit bsy, input bit dn, input logic [2:0] cur);
        return {run, sel, t, stb, bsy, dn, cur};
    endfunction

    // Expected outputs, one entry per clock starting the cycle after start is sampled
    function automatic void build(input logic [3:0] m, input logic [2:0] r, input logic [15:0] d,
                                  input logic [7:0] t, input int passes);
        int div, n;
        exp_q.delete();
        div = (r == 3'd0) ? 256 : (r == 3'd1) ? 512 : (r == 3'd3) ? 1115 : (r == 3'd4) ? 557 : 1024;
        n = (d == 16'd0) ? 1 : int'(d);
        if (m == 4'd0) begin
            exp_q.push_back(pk(0, 0, 0, 0, 1, 0, 0));
            exp_q.push_back(pk(0, 0, 0, 0, 0, 1, 0));
            return;
        end
        for (int p = 0; p < passes; p++)
            for (int md = 1; md <= 4; md++)
                if (m[md-1]) begin
                    exp_q.push_back(pk(0, 0, 0, 0, 1, 0, 0));
                    exp_q.push_back(pk(0, 0, 0, 0, 1, 0, 0));
                    for (int c = 0; c <= div * n; c++)
                        exp_q.push_back(pk(1, 3'(md), (md == 3) ? t : 8'd0,
                                           c > 0 && c % div == 0, 1, 0, 3'(md)));
                end
        if (!LOOP) begin
            exp_q.push_back(pk(0, 0, 0, 0, 1, 0, 0));
            exp_q.push_back(pk(0, 0, 0, 0, 0, 1, 0));
        end
    endfunction

    task automatic chk(input string nm, input logic [17:0] a, input logic [17:0] e, output bit ok);
        n_checks++;
        ok = (a === e);
        if (!ok) begin
            n_errors++;
            $display("FAIL %s at %0t: outputs got %h expected %h", nm, $time, a, e);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        n_checks++;
        if (a != e) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic run_seq(input string nm, input logic [3:0] m, input logic [2:0] r, input logic [15:0] d,
                           input logic [7:0] t, input bit tamper, input int passes, input bit abort_end,
                           output int stb, output logic [15:0] seen, output int done_at);
        int len, kp;
        bit ok;
        logic [2:0] last;
        build(m, r, d, t, passes);
        len = exp_q.size();
        stb = 0;
        seen = '0;
        done_at = -1;
        last = '0;
        ok = 1'b1;
        kp = (tamper && len > 3) ? int'($urandom_range(len - 3, 0)) : -1;
        @(posedge clk); #1;
        mask = m; rate_sel = r; dwell = d; tinc = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (tamper) begin
            mask = 4'($urandom); rate_sel = 3'($urandom); dwell = 16'($urandom); tinc = 8'($urandom);
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk(nm, act, exp_q[i], ok);
            stb += int'(smp_strobe);
            if (cur_mode != 3'd0 && cur_mode != last)
                seen = {seen[11:0], 1'b0, cur_mode};
            last = cur_mode;
            if (done)
                done_at = i + 1;
            start = (i == kp);
            if (!ok)
                break;
        end
        start = 1'b0;
        if (abort_end || !ok) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk({nm, " abort"}, act, 18'd0, ok);
        end else begin
            @(negedge clk);
            chk({nm, " idle"}, act, 18'd0, ok);
        end
    endtask

    task automatic abort_test();
        bit ok;
        @(posedge clk); #1;
        mask = 4'b0001; rate_sel = 3'd0; dwell = 16'd3; tinc = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i <= 258; i++)
            @(negedge clk);
        chk_int("abort strobe", int'(smp_strobe), 1);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort next", act, 18'd0, ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort stays idle", act, 18'd0, ok);
        end
    endtask

    initial begin
        vec_t        tbl[6];
        int          stb, done_at;
        logic [15:0] seen;
        bit          ok;
        tbl[0] = '{"m0001 r0 d3",  4'b0001, 3'd0, 16'd3, 8'h00, 1'b0, 773,  3, 16'h0001};
        tbl[1] = '{"m1010 r3 d2",  4'b1010, 3'd3, 16'd2, 8'h15, 1'b1, 4468, 4, 16'h0024};
        tbl[2] = '{"m0100 d0",     4'b0100, 3'd0, 16'd0, 8'h2a, 1'b0, 261,  1, 16'h0003};
        tbl[3] = '{"m0000",        4'b0000, 3'd0, 16'd5, 8'h00, 1'b0, 2,    0, 16'h0000};
        tbl[4] = '{"m1111 r4 d1",  4'b1111, 3'd4, 16'd1, 8'h7f, 1'b1, 2242, 4, 16'h1234};
        tbl[5] = '{"m0100 r6 d1",  4'b0100, 3'd6, 16'd1, 8'h81, 1'b0, 1029, 1, 16'h0003};
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        rate_sel = '0; dwell = '0; mask = '0; tinc = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset", act, 18'd0, ok);
`ifndef FE_SEQ_LOOP_EN
        for (int v = 0; v < 6; v++) begin
            run_seq(tbl[v].name, tbl[v].mask, tbl[v].rate, tbl[v].dwell, tbl[v].tinc,
                    tbl[v].tamper, 1, 1'b0, stb, seen, done_at);
            chk_int({tbl[v].name, " done cycle"}, done_at, tbl[v].exp_len);
            chk_int({tbl[v].name, " strobes"}, stb, tbl[v].exp_stb);
            chk_int({tbl[v].name, " modes"}, int'(seen), int'(tbl[v].exp_modes));
        end
        abort_test();
        for (int n = 0; n < 6; n++)
            run_seq("random", 4'($urandom), 3'($urandom), 16'($urandom_range(2, 0)), 8'($urandom),
                    1'b1, 1, 1'b0, stb, seen, done_at);
`else
        run_seq("loop m0011", 4'b0011, 3'd0, 16'd1, 8'h00, 1'b0, 3, 1'b1, stb, seen, done_at);
        chk_int("loop strobes", stb, 6);
        chk_int("loop no done", done_at, -1);
        abort_test();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
